// File: rtl/tipi_pkg.sv
// Shared definitions for the TIPI Raspberry Pi serial port: register
// select encodings, the frame FSM state type and the default width.
package tipi_pkg;

   localparam int TIPI_WIDTH = 8;

   // rpi_rsel encodings: bit 1 set means the RPi is writing a register.
   localparam logic [1:0] RSEL_TD = 2'b00;
   localparam logic [1:0] RSEL_TC = 2'b01;
   localparam logic [1:0] RSEL_RD = 2'b10;
   localparam logic [1:0] RSEL_RC = 2'b11;

   typedef enum logic [2:0] {
      ARM,
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } tipi_state_e;

   // True when the select addresses an RPi-to-TI register (RD/RC).
   function automatic logic is_write_sel(input logic [1:0] sel);
      return sel[1];
   endfunction

endpackage

// File: rtl/tipi_sync_edge.sv
// Single-bit synchronizer for an asynchronous RPi GPIO line, followed by
// one extra registered copy used to decode rise/fall pulses.
module tipi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the pin through the synchronizer chain and keep the last level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the value
         // from before the edge, so the chain really has SYNC_STAGES stages.
         sync_q <= (sync_q << 1) | SYNC_STAGES'(async_i);
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

   // Edge pulses come straight from flop outputs, so they are glitch-free
   // and last exactly one clk.
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tipi_rpi_shift.sv
// Raspberry Pi side of the TIPI latches. The RPi clocks bytes serially over
// slow asynchronous GPIO: read frames return a tear-free snapshot of the TI
// written TD/TC latches, write frames load the RD/RC registers the TI reads.
module tipi_rpi_shift
   import tipi_pkg::*;
#(
   parameter int WIDTH       = TIPI_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rpi_sclk,
   input  logic             rpi_sdi,
   input  logic             rpi_le,
   input  logic [1:0]       rpi_rsel,
   output logic             rpi_sdo,
   input  logic [WIDTH-1:0] ti_data_q,
   input  logic [WIDTH-1:0] ti_control_q,
   output logic [WIDTH-1:0] rpi_data_q,
   output logic [WIDTH-1:0] rpi_control_q,
   output logic             rd_strobe,
   output logic             rc_strobe,
   output logic             frame_err
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   // ARM waits this many clk after reset so the le synchronizer reflects
   // the real pin level before it is trusted.
   localparam int ARM_SETTLE = SYNC_STAGES + 1;
   localparam int ARM_W      = $clog2(ARM_SETTLE + 1) + 1;

   // ---------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------
   logic       sclk_rise;
   logic       le_sync, le_rise, le_fall;
   logic       sdi_sync;
   logic [1:0] rsel_sync;

   logic       sclk_sync_unused, sclk_fall_unused;
   logic       sdi_rise_unused, sdi_fall_unused;
   logic [1:0] rsel_rise_unused, rsel_fall_unused;

   tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rpi_sclk),
      .sync_o  (sclk_sync_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall_unused)
   );

   tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rpi_le),
      .sync_o  (le_sync),
      .rise_o  (le_rise),
      .fall_o  (le_fall)
   );

   // Same depth as sclk, so sdi_sync is the bit the RPi set up before the
   // sclk rise that is being detected this cycle.
   tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rpi_sdi),
      .sync_o  (sdi_sync),
      .rise_o  (sdi_rise_unused),
      .fall_o  (sdi_fall_unused)
   );

   for (genvar g = 0; g < 2; g++) begin : g_rsel_sync
      tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rsel (
         .clk     (clk),
         .rst_n   (rst_n),
         .async_i (rpi_rsel[g]),
         .sync_o  (rsel_sync[g]),
         .rise_o  (rsel_rise_unused[g]),
         .fall_o  (rsel_fall_unused[g])
      );
   end

   // ---------------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------------
   tipi_state_e      state_q, state_d;
   logic [1:0]       frame_sel_q, frame_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic             sample_vld_q, sample_vld_d;
   logic             overrun_q, overrun_d;
   logic             sdo_q, sdo_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [WIDTH-1:0] rpi_data_d, rpi_control_d;
   logic             rd_strobe_q, rd_strobe_d;
   logic             rc_strobe_q, rc_strobe_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] sel_latch;
   logic             frame_ok;

   assign sel_latch = (frame_sel_q == RSEL_TC) ? ti_control_q : ti_data_q;
   assign frame_ok  = (cnt_q == CNT_W'(WIDTH)) && !overrun_q;

   // Next-state and output decode for the frame FSM.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d       = state_q;
      frame_sel_d   = frame_sel_q;
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      sample_d      = sample_q;
      sample_vld_d  = sample_vld_q;
      overrun_d     = overrun_q;
      sdo_d         = sdo_q;
      arm_cnt_d     = arm_cnt_q;
      rpi_data_d    = rpi_data_q;
      rpi_control_d = rpi_control_q;
      rd_strobe_d   = 1'b0;
      rc_strobe_d   = 1'b0;
      frame_err_d   = 1'b0;

      unique case (state_q)
         ARM: begin
            // Refuse to start until le is seen low, so a le held high
            // through reset cannot open a partial frame.
            if (arm_cnt_q != ARM_W'(ARM_SETTLE)) begin
               arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end else if (!le_sync) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            sdo_d = 1'b0;
            if (le_rise) begin
               frame_sel_d  = rsel_sync;
               cnt_d        = '0;
               overrun_d    = 1'b0;
               sample_vld_d = 1'b0;
               shift_d      = '0;
               state_d      = is_write_sel(rsel_sync) ? SHIFT : LOAD;
            end
         end

         LOAD: begin
            // Two equal consecutive samples mean no TI write was in flight,
            // so the snapshot cannot be torn.
            sample_d     = sel_latch;
            sample_vld_d = 1'b1;
            if (le_fall) begin
               state_d = DONE;
            end else if (sample_vld_q && (sel_latch == sample_q)) begin
               shift_d = sel_latch;
               sdo_d   = sel_latch[WIDTH-1];
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (sclk_rise) begin
               if (cnt_q < CNT_W'(WIDTH)) begin
                  if (is_write_sel(frame_sel_q)) begin
                     shift_d = {shift_q[WIDTH-2:0], sdi_sync};
                  end else begin
                     shift_d = {shift_q[WIDTH-2:0], 1'b0};
                     sdo_d   = shift_q[WIDTH-2];
                  end
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  overrun_d = 1'b1;
               end
            end
            // A bit arriving with le fall is taken first; DONE then sees
            // the updated count.
            if (le_fall) begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (!frame_ok) begin
               frame_err_d = 1'b1;
            end else if (frame_sel_q == RSEL_RD) begin
               rpi_data_d  = shift_q;
               rd_strobe_d = 1'b1;
            end else if (frame_sel_q == RSEL_RC) begin
               rpi_control_d = shift_q;
               rc_strobe_d   = 1'b1;
            end
            state_d = IDLE;
         end

         default: state_d = ARM;
      endcase
   end

   // Register all frame state and outputs; reset abandons any open frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ARM;
         frame_sel_q   <= RSEL_TD;
         cnt_q         <= '0;
         shift_q       <= '0;
         sample_q      <= '0;
         sample_vld_q  <= 1'b0;
         overrun_q     <= 1'b0;
         sdo_q         <= 1'b0;
         arm_cnt_q     <= '0;
         rpi_data_q    <= '0;
         rpi_control_q <= '0;
         rd_strobe_q   <= 1'b0;
         rc_strobe_q   <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_sel_q   <= frame_sel_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         sample_q      <= sample_d;
         sample_vld_q  <= sample_vld_d;
         overrun_q     <= overrun_d;
         sdo_q         <= sdo_d;
         arm_cnt_q     <= arm_cnt_d;
         rpi_data_q    <= rpi_data_d;
         rpi_control_q <= rpi_control_d;
         rd_strobe_q   <= rd_strobe_d;
         rc_strobe_q   <= rc_strobe_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign rpi_sdo   = sdo_q;
   assign rd_strobe = rd_strobe_q;
   assign rc_strobe = rc_strobe_q;
   assign frame_err = frame_err_q;

endmodule
